edf_queue_scheduler: RTL and testbench

- Earliest-Deadline-First scheduler that sequences the queueing domain by choosing which per-core queue is served next.
- Drives core_id and the single-cycle readiness edge into the queueing domain, then captures the returned packet.
- Hands the captured packet to the downstream serializer over a valid/ready handshake.
- Keeps one deadline counter per queue and reloads a queue's counter each time that queue is served.

---
 rtl/edf_queue_scheduler.sv | 128 ++++++++++++
 tb/tb_edf_queue_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edf_queue_scheduler.sv
// edf_queue_scheduler: earliest-deadline-first pick of the next per-core
// queue, request/capture of its head packet, valid/ready hand-off out.
// Ports: clock, reset (async, active-low); enable, periods, empty in;
// scheduler_to_queues_ready, core_id out; queues_to_serializer_valid and
// queues_to_serializer_packet in; out_packet, out_valid out; out_ready in;
// timeout_error, busy out.
module edf_queue_scheduler #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 32,
  parameter int DATA_SIZE        = 678,
  parameter int WAIT_TIMEOUT     = 64,
  localparam int IW = (NUMBER_OF_QUEUES > 1) ?
                      $clog2(NUMBER_OF_QUEUES) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] periods,
  input  logic [NUMBER_OF_QUEUES-1:0] empty,
  output logic                 scheduler_to_queues_ready,
  output logic [IW-1:0]        core_id,
  input  logic                 queues_to_serializer_valid,
  input  logic [DATA_SIZE-1:0] queues_to_serializer_packet,
  output logic [DATA_SIZE-1:0] out_packet,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 timeout_error,
  output logic                 busy
);

  localparam int CW = $clog2(WAIT_TIMEOUT);
  localparam logic [CW-1:0] WLAST = CW'(WAIT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, REQUEST, WAIT_VALID, OUTPUT
  } state_t;

  state_t state_q, state_d;

  logic [REGISTER_SIZE-1:0] deadline [NUMBER_OF_QUEUES];
  logic [CW-1:0]            wait_cnt;
  logic                     loaded;
  logic                     capture;

  logic                     found;
  logic [IW-1:0]            win;
  logic [REGISTER_SIZE-1:0] best;

  // Strict less-than keeps the lowest index on equal deadlines.
  always_comb begin
    found = 1'b0;
    win   = '0;
    best  = '0;
    for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
      if (!empty[i] && (!found || deadline[i] < best)) begin
        found = 1'b1;
        win   = IW'(i);
        best  = deadline[i];
      end
    end
  end

  // No decision until the deadlines hold their first load.
  always_comb begin
    state_d       = state_q;
    capture       = 1'b0;
    timeout_error = 1'b0;
    unique case (state_q)
      IDLE:
        if (loaded && enable && found)
          state_d = REQUEST;
      REQUEST:
        state_d = WAIT_VALID;
      WAIT_VALID:
        if (queues_to_serializer_valid) begin
          capture = 1'b1;
          state_d = OUTPUT;
        end else if (wait_cnt == WLAST) begin
          timeout_error = 1'b1;
          state_d       = IDLE;
        end
      OUTPUT:
        if (out_ready)
          state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      core_id    <= '0;
      out_packet <= '0;
      out_valid  <= 1'b0;
      wait_cnt   <= '0;
      loaded     <= 1'b0;
      for (int i = 0; i < NUMBER_OF_QUEUES; i++)
        deadline[i] <= '0;
    end else begin
      state_q <= state_d;
      loaded  <= 1'b1;
      if (state_q == IDLE && state_d == REQUEST)
        core_id <= win;
      if (state_q == WAIT_VALID)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (capture) begin
        out_packet <= queues_to_serializer_packet;
        out_valid  <= 1'b1;
      end else if (state_q == OUTPUT && out_ready) begin
        out_valid <= 1'b0;
      end
      // Reload beats decrement; zero is sticky until served.
      for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
        if (!loaded || (capture && core_id == IW'(i)))
          deadline[i] <= periods[i];
        else if (deadline[i] != '0)
          deadline[i] <= deadline[i] - 1'b1;
      end
    end
  end

  assign scheduler_to_queues_ready = (state_q == REQUEST);
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_edf_queue_scheduler.sv
// tb_edf_queue_scheduler: directed bench for edf_queue_scheduler.
// Acts as the queueing domain and the serializer.
module tb_edf_queue_scheduler;

  localparam int NQ = 4;
  localparam int RS = 32;
  localparam int DS = 678;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic                   enable = 1'b1;
  logic [NQ-1:0][RS-1:0]  periods = '0;
  logic [NQ-1:0]          empty = '0;
  logic                   ready;
  logic [1:0]             core_id;
  logic                   valid = 1'b0;
  logic [DS-1:0]          packet = '0;
  logic [DS-1:0]          out_packet;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic                   timeout_error;
  logic                   busy;

  int n_cmp = 0;
  int n_bad = 0;

  edf_queue_scheduler dut (
    .clock                       (clock),
    .reset                       (reset),
    .enable                      (enable),
    .periods                     (periods),
    .empty                       (empty),
    .scheduler_to_queues_ready   (ready),
    .core_id                     (core_id),
    .queues_to_serializer_valid  (valid),
    .queues_to_serializer_packet (packet),
    .out_packet                  (out_packet),
    .out_valid                   (out_valid),
    .out_ready                   (out_ready),
    .timeout_error               (timeout_error),
    .busy                        (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [DS-1:0] got,
                     input logic [DS-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DS-1:0] mk(input int n);
    logic [31:0] w;
    w = n ^ 32'h5a5a_0000;
    return {n[5:0], {21{w}}};
  endfunction

  task automatic set_p(input int a, input int b,
                       input int c, input int d);
    periods[0] = RS'(a);
    periods[1] = RS'(b);
    periods[2] = RS'(c);
    periods[3] = RS'(d);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    valid = 1'b0;
    tick();
    chk("rst_ready", ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_core", core_id, 0);
    chk("rst_pkt", out_packet, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dl", dut.deadline[2], 0);
    reset = 1'b1;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!ready && n < 30) begin
      tick();
      n++;
    end
    chk("req_seen", ready, 1);
  endtask

  // Called in the REQUEST cycle; leaves the DUT in OUTPUT.
  task automatic respond(input logic [DS-1:0] p);
    tick();
    chk("wait_rdy_low", ready, 0);
    valid  = 1'b1;
    packet = p;
    tick();
    valid = 1'b0;
    chk("cap_valid", out_valid, 1);
    chk("cap_pkt", out_packet, p);
  endtask

  initial begin
    logic [DS-1:0] p;
    bit            seen_r;
    bit            seen_b;
    bit            stable;
    int            n;

    // 1: basic EDF pick and latency
    set_p(100, 50, 200, 80);
    empty = 4'b0000;
    do_reset();
    tick();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_rdy", ready, 0);
    tick();
    chk("t1_rdy", ready, 1);
    chk("t1_core", core_id, 1);
    p = mk(1);
    respond(p);
    chk("t1_reload", dut.deadline[1], 50);
    chk("t1_dl0", dut.deadline[0], 97);
    tick();
    chk("t1_drop", out_valid, 0);
    chk("t1_idle", busy, 0);

    // 2: equal periods rotate 0,1,2,3
    set_p(10, 10, 10, 10);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      wait_req();
      chk($sformatf("t2_core%0d", k), core_id, k);
      respond(mk(20 + k));
      tick();
    end

    // 3: lone candidate with the largest period
    set_p(10, 20, 1000, 30);
    empty = 4'b1011;
    do_reset();
    wait_req();
    chk("t3_core", core_id, 2);
    respond(mk(3));
    tick();
    empty = 4'b1111;
    valid = 1'b1;
    packet = mk(99);
    tick();
    valid = 1'b0;
    chk("t3_stray_valid", out_valid, 0);
    chk("t3_stray_pkt", out_packet, mk(3));
    seen_r = 0;
    seen_b = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      seen_r |= ready;
      seen_b |= busy;
    end
    chk("t3_no_req", seen_r, 0);
    chk("t3_no_busy", seen_b, 0);

    // 4: serializer back-pressure
    set_p(100, 50, 200, 80);
    empty = 4'b0000;
    out_ready = 1'b0;
    do_reset();
    wait_req();
    p = mk(4);
    respond(p);
    stable = 1;
    seen_r = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid !== 1'b1 || out_packet !== p)
        stable = 0;
      seen_r |= ready;
    end
    chk("t4_stable", stable, 1);
    chk("t4_no_req", seen_r, 0);
    out_ready = 1'b1;
    tick();
    chk("t4_drop", out_valid, 0);
    chk("t4_idle", busy, 0);

    // 5: timeout without valid
    set_p(300, 100, 400, 500);
    do_reset();
    wait_req();
    chk("t5_core", core_id, 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!timeout_error && n < 100);
    chk("t5_to_cycles", n, 64);
    chk("t5_no_reload", dut.deadline[1], 35);
    tick();
    chk("t5_to_pulse", timeout_error, 0);
    chk("t5_idle", busy, 0);
    chk("t5_novalid", out_valid, 0);
    tick();
    chk("t5_rereq", ready, 1);
    chk("t5_recore", core_id, 1);

    // 6: async reset during OUTPUT
    set_p(100, 50, 200, 80);
    out_ready = 1'b0;
    do_reset();
    wait_req();
    respond(mk(6));
    #2;
    reset = 1'b0;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_ready", ready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_pkt", out_packet, 0);
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    wait_req();
    chk("t6_core", core_id, 1);
    chk("t6_dl", dut.deadline[1], 49);
    respond(mk(7));
    tick();
    chk("t6_done", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
